// File: rtl/sc_comp_pkg.sv
// sc_comp_pkg: opcode/funct encodings and decode select types shared by the
// single-cycle MIPS-subset computer.
package sc_comp_pkg;
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR,
      ALU_SLT, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA
   } alu_op_e;

   typedef enum logic [1:0] {NPC_SEQ, NPC_BR, NPC_J, NPC_JR} npc_sel_e;

   typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_sel_e;
endpackage

// File: rtl/sc_comp_cpu.sv
// sc_cpu: single-cycle core (decode, ALU, next-PC, register file U_RF).
// sll/srl/sra decode only when SC_COMP_SHIFT_EN is defined.
module sc_rf
   import sc_comp_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  ra3,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic [31:0] rd3
);
   logic [31:0] rf [0:31];

   always_ff @(posedge clk or negedge rstn)
      if (!rstn)
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      else if (we && wa != 5'd0)
         rf[wa] <= wd;

   assign rd1 = (ra1 == 5'd0) ? '0 : rf[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : rf[ra2];
   assign rd3 = (ra3 == 5'd0) ? '0 : rf[ra3];
endmodule

module sc_cpu
   import sc_comp_pkg::*;
#(
   parameter int DM_AW = 7
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [31:0]      instr,
   output logic [31:0]      PC,
   output logic [DM_AW-1:0] dm_addr,
   output logic [31:0]      dm_wdata,
   output logic             dm_we,
   input  logic [31:0]      dm_rdata,
   input  logic [4:0]       reg_sel,
   output logic [31:0]      reg_data
);
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt, wa;
   logic [15:0] imm;
   logic [31:0] rs_v, rt_v, alu_b, alu_y, wd, pc4, pc_d;
   logic        rf_we, b_imm, zext, ld;
   alu_op_e     alu_op;
   npc_sel_e    npc;
   dst_sel_e    dst;

   assign {op, rs, rt, rd, shamt, funct} = instr;
   assign imm = instr[15:0];

   always_comb begin
      rf_we  = 1'b0;
      dst    = DST_RT;
      alu_op = ALU_ADD;
      b_imm  = 1'b0;
      zext   = 1'b0;
      dm_we  = 1'b0;
      ld     = 1'b0;
      npc    = NPC_SEQ;
      case (op)
         OP_R: case (funct)
            FN_ADD: begin rf_we = 1'b1; dst = DST_RD; end
            FN_SUB: begin rf_we = 1'b1; dst = DST_RD; alu_op = ALU_SUB; end
            FN_AND: begin rf_we = 1'b1; dst = DST_RD; alu_op = ALU_AND; end
            FN_OR:  begin rf_we = 1'b1; dst = DST_RD; alu_op = ALU_OR; end
            FN_NOR: begin rf_we = 1'b1; dst = DST_RD; alu_op = ALU_NOR; end
            FN_SLT: begin rf_we = 1'b1; dst = DST_RD; alu_op = ALU_SLT; end
            FN_JR:  npc = NPC_JR;
`ifdef SC_COMP_SHIFT_EN
            FN_SLL: begin rf_we = 1'b1; dst = DST_RD; alu_op = ALU_SLL; end
            FN_SRL: begin rf_we = 1'b1; dst = DST_RD; alu_op = ALU_SRL; end
            FN_SRA: begin rf_we = 1'b1; dst = DST_RD; alu_op = ALU_SRA; end
`endif
            default: ;
         endcase
         OP_ADDI: begin rf_we = 1'b1; b_imm = 1'b1; end
         OP_SLTI: begin rf_we = 1'b1; b_imm = 1'b1; alu_op = ALU_SLT; end
         OP_ANDI: begin rf_we = 1'b1; b_imm = 1'b1; zext = 1'b1; alu_op = ALU_AND; end
         OP_ORI:  begin rf_we = 1'b1; b_imm = 1'b1; zext = 1'b1; alu_op = ALU_OR; end
         OP_LUI:  begin rf_we = 1'b1; b_imm = 1'b1; alu_op = ALU_LUI; end
         OP_LW:   begin rf_we = 1'b1; b_imm = 1'b1; ld = 1'b1; end
         OP_SW:   begin b_imm = 1'b1; dm_we = 1'b1; end
         OP_BEQ:  npc = (rs_v == rt_v) ? NPC_BR : NPC_SEQ;
         OP_BNE:  npc = (rs_v != rt_v) ? NPC_BR : NPC_SEQ;
         OP_J:    npc = NPC_J;
         OP_JAL:  begin npc = NPC_J; rf_we = 1'b1; dst = DST_RA; end
         default: ;
      endcase
   end

   assign alu_b = !b_imm ? rt_v : zext ? {16'h0, imm} : {{16{imm[15]}}, imm};

   always_comb begin
      alu_y = '0;
      case (alu_op)
         ALU_ADD: alu_y = rs_v + alu_b;
         ALU_SUB: alu_y = rs_v - alu_b;
         ALU_AND: alu_y = rs_v & alu_b;
         ALU_OR:  alu_y = rs_v | alu_b;
         ALU_NOR: alu_y = ~(rs_v | alu_b);
         ALU_SLT: alu_y = {31'd0, $signed(rs_v) < $signed(alu_b)};
         ALU_LUI: alu_y = {imm, 16'h0};
         ALU_SLL: alu_y = alu_b << shamt;
         ALU_SRL: alu_y = alu_b >> shamt;
         ALU_SRA: alu_y = $signed(alu_b) >>> shamt;
         default: alu_y = '0;
      endcase
   end

   assign pc4 = PC + 32'd4;
   assign wa  = (dst == DST_RD) ? rd : (dst == DST_RA) ? 5'd31 : rt;
   assign wd  = (dst == DST_RA) ? pc4 : ld ? dm_rdata : alu_y;
   assign pc_d = (npc == NPC_BR) ? pc4 + {{14{imm[15]}}, imm, 2'b00} :
                 (npc == NPC_J)  ? {pc4[31:28], instr[25:0], 2'b00} :
                 (npc == NPC_JR) ? rs_v : pc4;

   assign dm_addr  = alu_y[DM_AW+1:2];
   assign dm_wdata = rt_v;

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) PC <= '0;
      else       PC <= pc_d;

   sc_rf U_RF (
      .clk(clk), .rstn(rstn), .we(rf_we), .wa(wa), .wd(wd),
      .ra1(rs), .ra2(rt), .ra3(reg_sel),
      .rd1(rs_v), .rd2(rt_v), .rd3(reg_data)
   );
endmodule

// File: rtl/sc_comp.sv
// sc_comp: single-cycle MIPS-subset computer (core U_SCPU, ROM U_IM, RAM U_DM).
// Define SC_COMP_SHIFT_EN to add sll/srl/sra.
module sc_im #(
   parameter int DEPTH = 128
) (
   input  logic [$clog2(DEPTH)-1:0] addr,
   output logic [31:0]              data
);
   logic [31:0] ROM [0:DEPTH-1];

   assign data = ROM[addr];
endmodule

module sc_dm #(
   parameter int DEPTH = 128
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wd,
   output logic [31:0]              rd
);
   logic [31:0] ram [0:DEPTH-1];

   always_ff @(posedge clk)
      if (we) ram[addr] <= wd;

   assign rd = ram[addr];
endmodule

module sc_comp
   import sc_comp_pkg::*;
#(
   parameter int IM_DEPTH = 128,
   parameter int DM_DEPTH = 128
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [4:0]  reg_sel,
   output logic [31:0] reg_data
);
   localparam int IM_AW = $clog2(IM_DEPTH);
   localparam int DM_AW = $clog2(DM_DEPTH);

   logic [31:0]      PC, instr, dm_wdata, dm_rdata;
   logic [DM_AW-1:0] dm_addr;
   logic             dm_we;

   sc_cpu #(.DM_AW(DM_AW)) U_SCPU (
      .clk(clk), .rstn(rstn), .instr(instr), .PC(PC),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
      .reg_sel(reg_sel), .reg_data(reg_data)
   );

   sc_im #(.DEPTH(IM_DEPTH)) U_IM (.addr(PC[IM_AW+1:2]), .data(instr));

   sc_dm #(.DEPTH(DM_DEPTH)) U_DM (
      .clk(clk), .we(dm_we), .addr(dm_addr), .wd(dm_wdata), .rd(dm_rdata)
   );
endmodule

// File: tb/tb_sc_comp.sv
// tb_sc_comp: directed program run through sc_comp with hand-computed register/PC expectations.
`timescale 1ns/1ps
module tb_sc_comp;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [4:0]  reg_sel = '0;
   logic [31:0] reg_data;
   int          tests = 0;
   int          fails = 0;

   sc_comp dut (.clk(clk), .rstn(rstn), .reg_sel(reg_sel), .reg_data(reg_data));

   always #50 clk = ~clk;

   function automatic logic [31:0] r_i(input int rs, input int rt, input int rd, input int sh, input int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction

   function automatic logic [31:0] i_i(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] j_i(input int op, input int addr);
      return {6'(op), 26'(addr >> 2)};
   endfunction

   task automatic put(input int addr, input logic [31:0] w);
      dut.U_IM.ROM[addr >> 2] = w;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [31:0] exp10, exp11;
`ifdef SC_COMP_SHIFT_EN
      exp10 = 32'h0000_0050;
      exp11 = 32'hFFFF_FFFE;
`else
      exp10 = 32'h0;
      exp11 = 32'h0;
`endif
      for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] = 32'h0;
      put(32'h00, i_i(8'h0D, 0, 1, 16'hFFFF));
      put(32'h04, i_i(8'h0F, 0, 2, 16'h00FF));
      put(32'h08, i_i(8'h0D, 2, 2, 16'h00FF));
      put(32'h0C, r_i(1, 2, 3, 0, 8'h27));
      put(32'h10, i_i(8'h08, 0, 4, 5));
      put(32'h14, i_i(8'h08, 0, 5, -3));
      put(32'h18, r_i(4, 5, 6, 0, 8'h20));
      put(32'h1C, r_i(5, 4, 7, 0, 8'h22));
      put(32'h20, r_i(5, 4, 8, 0, 8'h2A));
      put(32'h24, i_i(8'h2B, 0, 4, 8));
      put(32'h28, i_i(8'h23, 0, 9, 8));
      put(32'h2C, i_i(8'h08, 0, 0, 7));
      put(32'h30, i_i(8'h04, 4, 4, 1));
      put(32'h34, i_i(8'h08, 0, 12, 1));
      put(32'h38, j_i(8'h02, 32'h48));
      put(32'h3C, i_i(8'h08, 0, 13, 1));
      put(32'h40, i_i(8'h08, 0, 13, 1));
      put(32'h44, i_i(8'h08, 0, 13, 1));
      put(32'h48, i_i(8'h05, 4, 4, 1));
      put(32'h4C, i_i(8'h05, 4, 5, 1));
      put(32'h50, i_i(8'h08, 0, 14, 1));
      put(32'h54, j_i(8'h03, 32'h60));
      put(32'h58, i_i(8'h08, 0, 15, 9));
      put(32'h5C, j_i(8'h02, 32'h70));
      put(32'h60, i_i(8'h08, 0, 16, 3));
      put(32'h64, r_i(31, 0, 0, 0, 8'h08));
      put(32'h70, r_i(0, 4, 10, 4, 8'h00));
      put(32'h74, r_i(0, 5, 11, 1, 8'h03));
      put(32'h78, j_i(8'h02, 32'h78));

      #1;
      chk("pc_in_reset", dut.PC, 32'h0);
      for (int i = 0; i < 32; i++) chk($sformatf("rf%0d_reset", i), dut.U_SCPU.U_RF.rf[i], 32'h0);
      for (int i = 0; i < 32; i++) begin
         reg_sel = 5'(i);
         #0.25;
         chk($sformatf("reg_data%0d_reset", i), reg_data, 32'h0);
      end
      #11 rstn = 1'b1;

      tick(1);
      chk("pc_first_edge", dut.PC, 32'h4);
      chk("rf1_ori", dut.U_SCPU.U_RF.rf[1], 32'h0000_FFFF);
      tick(3);
      chk("rf2_lui_ori", dut.U_SCPU.U_RF.rf[2], 32'h00FF_00FF);
      chk("rf3_nor", dut.U_SCPU.U_RF.rf[3], 32'hFF00_0000);
      reg_sel = 5'd3;
      #1 chk("reg_data3", reg_data, 32'hFF00_0000);
      tick(5);
      chk("pc_0x24", dut.PC, 32'h24);
      chk("rf4_addi", dut.U_SCPU.U_RF.rf[4], 32'h0000_0005);
      chk("rf5_addi_neg", dut.U_SCPU.U_RF.rf[5], 32'hFFFF_FFFD);
      chk("rf6_add", dut.U_SCPU.U_RF.rf[6], 32'h0000_0002);
      chk("rf7_sub", dut.U_SCPU.U_RF.rf[7], 32'hFFFF_FFF8);
      chk("rf8_slt", dut.U_SCPU.U_RF.rf[8], 32'h0000_0001);
      tick(3);
      chk("rf9_lw", dut.U_SCPU.U_RF.rf[9], 32'h0000_0005);
      chk("rf0_write", dut.U_SCPU.U_RF.rf[0], 32'h0);
      reg_sel = 5'd0;
      #1 chk("reg_data0", reg_data, 32'h0);
      chk("pc_0x30", dut.PC, 32'h30);
      tick(1);
      chk("pc_beq_taken", dut.PC, 32'h38);
      tick(1);
      chk("pc_j", dut.PC, 32'h48);
      tick(1);
      chk("pc_bne_not_taken", dut.PC, 32'h4C);
      tick(1);
      chk("pc_bne_taken", dut.PC, 32'h54);
      tick(1);
      chk("pc_jal", dut.PC, 32'h60);
      chk("rf31_jal", dut.U_SCPU.U_RF.rf[31], 32'h58);
      tick(2);
      chk("rf16", dut.U_SCPU.U_RF.rf[16], 32'h3);
      chk("pc_jr", dut.PC, 32'h58);
      tick(2);
      chk("rf15_after_return", dut.U_SCPU.U_RF.rf[15], 32'h9);
      chk("pc_j_shift", dut.PC, 32'h70);
      tick(2);
      chk("pc_after_shift", dut.PC, 32'h78);
      chk("rf10_sll", dut.U_SCPU.U_RF.rf[10], exp10);
      chk("rf11_sra", dut.U_SCPU.U_RF.rf[11], exp11);
      chk("rf12_skipped", dut.U_SCPU.U_RF.rf[12], 32'h0);
      chk("rf13_skipped", dut.U_SCPU.U_RF.rf[13], 32'h0);
      chk("rf14_skipped", dut.U_SCPU.U_RF.rf[14], 32'h0);
      tick(2);
      chk("pc_halt_loop", dut.PC, 32'h78);

      #10 rstn = 1'b0;
      #1;
      chk("pc_async_reset", dut.PC, 32'h0);
      chk("rf1_async_reset", dut.U_SCPU.U_RF.rf[1], 32'h0);
      #10 rstn = 1'b1;
      tick(1);
      chk("pc_restart", dut.PC, 32'h4);
      chk("rf1_restart", dut.U_SCPU.U_RF.rf[1], 32'h0000_FFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
